// File: rtl/commit_ctrl_pkg.sv
// Shared types for the dual-wide commit controller: FSM state encoding, ROB head view, default widths.
package commit_ctrl_pkg;

  localparam int NUM_PREGS_DEF = 64;
  localparam int NUM_AREGS_DEF = 32;
  localparam int XLEN_DEF      = 32;
  localparam int PREG_W        = $clog2(NUM_PREGS_DEF);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RESTORE = 2'd2,
    REBUILD = 2'd3
  } commit_state_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              regw;
    logic [4:0]        areg;
    logic [PREG_W-1:0] preg;
    logic              flush;
    logic [XLEN_DEF-1:0] tgt;
  } rob_head_t;

  function automatic logic [1:0] pop_count2(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/commit_ctrl_freelist_rebuilder.sv
// Captures which physical registers the RRF still maps, then scans them two per cycle
// and pushes every unmapped one back onto the free list.
module commit_ctrl_freelist_rebuilder
  import commit_ctrl_pkg::*;
#(
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  parameter int NUM_AREGS = NUM_AREGS_DEF,
  localparam int PW = $clog2(NUM_PREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture,
  input  logic                    scan,
  input  logic [NUM_AREGS*PW-1:0] rrf_map,
  output logic                    push0,
  output logic                    push1,
  output logic [PW-1:0]           preg0,
  output logic [PW-1:0]           preg1,
  output logic                    last
);

  logic [NUM_PREGS-1:0] mapped_q, mapped_d, map_now;
  logic [PW-1:0]        k_q, k_d, k_odd;

  // p0 is pinned as mapped so it never re-enters the free list.
  genvar gi;
  for (gi = 0; gi < NUM_PREGS; gi++) begin : g_map
    logic hit;
    always_comb begin
      hit = (gi == 0);
      for (int a = 0; a < NUM_AREGS; a++) begin
        if (rrf_map[a*PW +: PW] == PW'(gi)) hit = 1'b1;
      end
    end
    assign map_now[gi] = hit;
  end

  assign last  = (k_q == PW'(NUM_PREGS - 2));
  assign k_odd = k_q | PW'(1);

  always_comb begin
    mapped_d = capture ? map_now : mapped_q;
    k_d      = (scan && !last) ? k_q + PW'(2) : '0;
    push0    = scan & ~mapped_q[k_q];
    push1    = scan & ~mapped_q[k_odd];
    preg0    = scan ? k_q   : '0;
    preg1    = scan ? k_odd : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mapped_q <= '0;
      k_q      <= '0;
    end else begin
      mapped_q <= mapped_d;
      k_q      <= k_d;
    end
  end

endmodule

// File: rtl/commit_ctrl.sv
// Dual-wide retirement sequencer with flush/restore/rebuild recovery FSM.
// Optional performance counters are enabled by defining COMMIT_PERF_CNT_EN.
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  parameter int NUM_AREGS = NUM_AREGS_DEF,
  parameter int XLEN      = XLEN_DEF,
  localparam int PW = $clog2(NUM_PREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rob_valid0,
  input  logic                    rob_valid1,
  input  logic                    rob_done0,
  input  logic                    rob_done1,
  input  logic                    rob_regw0,
  input  logic                    rob_regw1,
  input  logic [4:0]              rob_areg0,
  input  logic [4:0]              rob_areg1,
  input  logic [PW-1:0]           rob_preg0,
  input  logic [PW-1:0]           rob_preg1,
  input  logic                    rob_flush0,
  input  logic                    rob_flush1,
  input  logic [XLEN-1:0]         rob_tgt0,
  input  logic [XLEN-1:0]         rob_tgt1,
  output logic                    rob_pop0,
  output logic                    rob_pop1,
  output logic                    rrf_we0,
  output logic                    rrf_we1,
  output logic [4:0]              rrf_areg0,
  output logic [4:0]              rrf_areg1,
  output logic [PW-1:0]           rrf_preg0,
  output logic [PW-1:0]           rrf_preg1,
  input  logic [PW-1:0]           rrf_old0,
  input  logic [PW-1:0]           rrf_old1,
  input  logic [NUM_AREGS*PW-1:0] rrf_map,
  output logic                    fl_push0,
  output logic                    fl_push1,
  output logic [PW-1:0]           fl_preg0,
  output logic [PW-1:0]           fl_preg1,
  output logic                    fl_clear,
  output logic                    rat_restore,
  output logic                    flush_o,
  output logic [XLEN-1:0]         redirect_pc,
  output logic                    busy
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [63:0]             perf_retired,
  output logic [63:0]             perf_flushes,
  output logic [63:0]             perf_recov_cycles
`endif
);

  localparam logic [1:0] S_RUN     = RUN;
  localparam logic [1:0] S_FLUSH   = FLUSH;
  localparam logic [1:0] S_RESTORE = RESTORE;
  localparam logic [1:0] S_REBUILD = REBUILD;

  if ((NUM_PREGS % 2) != 0 || NUM_PREGS <= NUM_AREGS || NUM_AREGS > 32 ||
      PW != PREG_W || XLEN != XLEN_DEF) begin : g_param_err
    $error("commit_ctrl: unsupported NUM_PREGS/NUM_AREGS/XLEN combination");
  end

  rob_head_t h0, h1;
  assign h0 = '{valid: rob_valid0, done: rob_done0, regw: rob_regw0, areg: rob_areg0,
                preg: rob_preg0, flush: rob_flush0, tgt: rob_tgt0};
  assign h1 = '{valid: rob_valid1, done: rob_done1, regw: rob_regw1, areg: rob_areg1,
                preg: rob_preg1, flush: rob_flush1, tgt: rob_tgt1};

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic            run, c0, c1, we0, we1;
  logic            rb_push0, rb_push1, rb_last, rb_capture, rb_scan;
  logic [PW-1:0]   rb_preg0, rb_preg1;

  always_comb begin
    // Reset gates the combinational commit path so every output reads 0 while rst is high.
    run = (state_q == S_RUN) && !rst;
    c0  = run & h0.valid & h0.done;
    c1  = c0 & ~h0.flush & h1.valid & h1.done;
    we0 = c0 & h0.regw & (h0.areg != 5'd0);
    we1 = c1 & h1.regw & (h1.areg != 5'd0);

    state_d    = state_q;
    redirect_d = redirect_q;
    case (state_q)
      S_RUN: begin
        if ((c0 & h0.flush) | (c1 & h1.flush)) begin
          state_d    = S_FLUSH;
          redirect_d = (c1 & h1.flush) ? h1.tgt : h0.tgt;
        end
      end
      S_FLUSH:   state_d = S_RESTORE;
      S_RESTORE: state_d = S_REBUILD;
      default:   if (rb_last) state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      redirect_q <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

  assign rb_capture = (state_q == S_RESTORE);
  assign rb_scan    = (state_q == S_REBUILD);

  commit_ctrl_freelist_rebuilder #(
    .NUM_PREGS (NUM_PREGS),
    .NUM_AREGS (NUM_AREGS)
  ) u_rebuild (
    .clk     (clk),
    .rst     (rst),
    .capture (rb_capture),
    .scan    (rb_scan),
    .rrf_map (rrf_map),
    .push0   (rb_push0),
    .push1   (rb_push1),
    .preg0   (rb_preg0),
    .preg1   (rb_preg1),
    .last    (rb_last)
  );

  assign rob_pop0    = c0;
  assign rob_pop1    = c1;
  assign rrf_we0     = we0;
  assign rrf_we1     = we1;
  assign rrf_areg0   = run ? h0.areg : 5'd0;
  assign rrf_areg1   = run ? h1.areg : 5'd0;
  assign rrf_preg0   = run ? h0.preg : '0;
  assign rrf_preg1   = run ? h1.preg : '0;
  assign fl_push0    = we0 | rb_push0;
  assign fl_push1    = we1 | rb_push1;
  assign fl_preg0    = we0 ? rrf_old0 : rb_preg0;
  assign fl_preg1    = we1 ? rrf_old1 : rb_preg1;
  assign fl_clear    = (state_q == S_FLUSH);
  assign flush_o     = (state_q == S_FLUSH);
  assign rat_restore = (state_q == S_RESTORE);
  assign redirect_pc = redirect_q;
  assign busy        = (state_q != S_RUN);

`ifdef COMMIT_PERF_CNT_EN
  logic [63:0] retired_q, retired_d, flushes_q, flushes_d, recov_q, recov_d;

  always_comb begin
    retired_d = retired_q + 64'(pop_count2(c0, c1));
    flushes_d = flushes_q + ((state_d == S_FLUSH && state_q != S_FLUSH) ? 64'd1 : 64'd0);
    recov_d   = recov_q + (busy ? 64'd1 : 64'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      flushes_q <= '0;
      recov_q   <= '0;
    end else begin
      retired_q <= retired_d;
      flushes_q <= flushes_d;
      recov_q   <= recov_d;
    end
  end

  assign perf_retired      = retired_q;
  assign perf_flushes      = flushes_q;
  assign perf_recov_cycles = recov_q;
`endif

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
Dual-wide retirement sequencer placed between the ROB head and the retirement register file (RRF).
- Decides each cycle whether 0, 1 or 2 ROB entries retire, and drives the RRF write and read ports.
- Returns each overwritten old physical register to the free list.
- On a committing mispredict or exception, runs the recovery FSM: flush, then restore the RAT from the RRF, then rebuild the free list from the RRF mappings.

Parameters:
NUM_PREGS, 64, physical register count; PREG_W = $clog2(NUM_PREGS).
NUM_AREGS, 32, architectural register count.
XLEN, 32, PC width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rob_valid0/1  in  1  ROB head / head+1 entry present
rob_done0/1  in  1  entry has finished execution
rob_regw0/1  in  1  entry writes rd
rob_areg0/1  in  5  rd architectural index
rob_preg0/1  in  PREG_W  rd physical register
rob_flush0/1  in  1  entry mispredicted or excepted
rob_tgt0/1  in  XLEN  redirect PC of entry
rob_pop0/1  out  1  retire head / head+1 (rob_pop1 implies rob_pop0)
rrf_we0/1  out  1  RRF commit enables
rrf_areg0/1  out  5  RRF commit arch index (also drives RRF read ports)
rrf_preg0/1  out  PREG_W  RRF commit physical register
rrf_old0/1  in  PREG_W  RRF old mapping; rrf_old1 already includes the port-0 same-cycle bypass
rrf_map  in  PREG_W x NUM_AREGS  full RRF mapping array
fl_push0/1  out  1  free-list push strobes
fl_preg0/1  out  PREG_W  pushed physical register
fl_clear  out  1  empty the free list
rat_restore  out  1  RAT copies rrf_map this cycle
flush_o  out  1  pipeline squash pulse
redirect_pc  out  XLEN  fetch redirect, valid with flush_o
busy  out  1  recovery in progress; rename stalls

Behaviour:
- FSM states: RUN, FLUSH, RESTORE, REBUILD. Reset state is RUN.
- Reset values: all outputs 0, scan counter 0, mapped bitmap 0. Reset may assert in any state and returns the block to RUN within the same cycle.
- After reset the RRF and free list self-initialise; the controller does no rebuild.
- RUN retire rules:
  - c0 = rob_valid0 & rob_done0.
  - c1 = c0 & !rob_flush0 & rob_valid1 & rob_done1.
  - rob_pop0 = c0; rob_pop1 = c1.
- RUN writeback rules:
  - rrf_weN = cN & rob_regwN & (rob_aregN != 0).
  - fl_pushN = rrf_weN, with fl_pregN = rrf_oldN.
  - All of these are combinational in the same cycle.
- Same-areg double commit: both writes issue; the RRF resolves it. fl_preg1 equals rob_preg0 via the RRF bypass.
- Flush trigger: if any retiring entry has flush set, latch that entry's target into redirect_pc and go to FLUSH next cycle.
  - Entry 1 is used if c1 & rob_flush1; otherwise entry 0.
- FLUSH (1 cycle): flush_o=1, fl_clear=1, no pops.
- RESTORE (1 cycle): rat_restore=1. Register a NUM_PREGS-bit mapped bitmap, setting bit rrf_map[i] for every i. The RRF is stable here because nothing commits.
- REBUILD:
  - Scan counter k starts at 0 and steps by 2 each cycle.
  - fl_push0 = !mapped[k] with fl_preg0 = k; fl_push1 = !mapped[k+1] with fl_preg1 = k+1.
  - Exit to RUN after the cycle with k = NUM_PREGS-2, so the phase lasts NUM_PREGS/2 cycles.
  - p0 (mapped to x0) is never pushed.
- busy = (state != RUN). No pops or RRF writes occur while busy.
- Total recovery: 2 + NUM_PREGS/2 cycles.
- NUM_PREGS must be even and greater than NUM_AREGS; out-of-range widths are a parameter error.

Optional Feature:
COMMIT_PERF_CNT_EN
- When defined: adds 64-bit counters perf_retired (+ popcount of pops), perf_flushes (+1 on entry to FLUSH) and perf_recov_cycles (+1 while busy). These are exposed as output ports and cleared by rst.
- When undefined: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared types package holds:
  - typedef commit_state_t {RUN, FLUSH, RESTORE, REBUILD}.
  - localparam PREG_W.
  - struct rob_head_t {valid, done, regw, areg, preg, flush, tgt}.
- Natural sub-module: freelist_rebuilder, containing the RESTORE bitmap capture plus the REBUILD scan and dual push.

Test Plan:
- Dual retire: head0 x5→p40 (old p5), head1 x6→p41 (old p6), both done → rrf_we0/1=1, fl_push p5 and p6, pops 1/1, busy=0.
- WAW: head0 x7→p42, head1 x7→p43, RRF old p7 → fl_preg0=p7, fl_preg1=p42, and the RRF ends with x7=p43.
- x0 and not-done: head0 areg=0 regw=1 done → pop0=1, rrf_we0=0, no push. If head1 is done but head0 is not → no pops.
- Mispredict: head0 flush=1 tgt=0x80000100, head1 done → only pop0. Next cycle flush_o=1, fl_clear=1, redirect_pc=0x80000100. Then rat_restore=1, then 32 REBUILD cycles.
- Rebuild content: RRF identity except x5=p40 → exactly 32 pushes, comprising p5 and p32..p63 excluding p40. p0 is never pushed; busy then drops.
- Async reset asserted mid-REBUILD (k=20) → outputs 0 immediately, state RUN, no further pushes.
